// File: rtl/bus_io_ctrl.sv
// bus_io_ctrl: memory/IO slave sitting directly behind proc core0.
// Decodes realaddr[15:12] into an on-chip word RAM plus LEDR, SW, KEY and a
// free-running timer. Read data comes back one cycle after the address, with
// no strobe. Writes are qualified by W at the rising edge of clk.
module bus_io_ctrl #(
  parameter int RAM_AW  = 12,
  parameter int TIMER_W = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] realaddr,
  input  logic [31:0] dout,
  input  logic        W,
  output logic [31:0] din,
  input  logic [9:0]  SW,
  input  logic [3:0]  KEY,
  output logic [9:0]  LEDR
);

  // Region codes for realaddr[15:12]; 0x0-0x7 is RAM, 0xC-0xF is unmapped.
  localparam logic [3:0] SEL_LEDR  = 4'h8;
  localparam logic [3:0] SEL_SW    = 4'h9;
  localparam logic [3:0] SEL_KEY   = 4'hA;
  localparam logic [3:0] SEL_TIMER = 4'hB;
  localparam logic [3:0] SEL_IDLE  = 4'hC;

  localparam int RAM_DEPTH = 2 ** RAM_AW;

  logic [3:0]         sel;
  logic [RAM_AW-1:0]  ram_idx;
  logic               ram_we;

  logic [31:0]        mem [RAM_DEPTH];
  logic [31:0]        ram_rd_q;

  logic [3:0]         sel_q;
  logic [31:0]        periph_q, periph_d;

  logic [9:0]         ledr_q, ledr_d;
  logic [9:0]         sw_meta_q, sw_sync_q;

  logic [3:0]         key_meta_q, key_sync_q, key_prev_q;
  logic [3:0]         press_q, press_d;
  logic [3:0]         key_new_edge;
  logic [3:0]         press_clr;

  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [31:0]        timer_ext;

  // Address bits above the decoded window are deliberately ignored.
  logic               unused_bits;
  assign unused_bits = ^{realaddr[31:16], dout};

  assign sel     = realaddr[15:12];
  assign ram_idx = realaddr[RAM_AW-1:0];
  assign ram_we  = W & ~sel[3];

  // RAM: one write and one read port; a same-edge read of the written word returns old data.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem[ram_idx] <= dout;
    end
    ram_rd_q <= mem[ram_idx];
  end

  // Key edges are taken on the synchronized pressed level (KEY is active-low).
  assign key_new_edge = key_sync_q & ~key_prev_q;
  assign press_clr    = (W && sel == SEL_KEY) ? dout[7:4] : 4'b0000;

  // Zero-extend the timer to the bus width for any TIMER_W.
  always_comb begin
    timer_ext = '0;
    timer_ext[TIMER_W-1:0] = timer_q;
  end

  // Next-state for the writable registers.
  always_comb begin
    ledr_d = ledr_q;
    if (W && sel == SEL_LEDR) begin
      ledr_d = dout[9:0];
    end

    // A new edge wins over a clear arriving on the same edge.
    press_d = (press_q & ~press_clr) | key_new_edge;

    timer_d = timer_q + TIMER_W'(1);
    if (W && sel == SEL_TIMER) begin
      timer_d = dout[TIMER_W-1:0];
    end
  end

  // Peripheral read mux, sampled at the same edge as the address.
  always_comb begin
    periph_d = 32'h0;
    case (sel)
      SEL_LEDR:  periph_d = {22'b0, ledr_q};
      SEL_SW:    periph_d = {22'b0, sw_sync_q};
      SEL_KEY:   periph_d = {24'b0, press_q, key_sync_q};
      SEL_TIMER: periph_d = timer_ext;
      default:   periph_d = 32'h0;
    endcase
  end

  // Control, synchronizer and peripheral state; RAM contents are not touched by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_q      <= SEL_IDLE;
      periph_q   <= 32'h0;
      ledr_q     <= 10'h0;
      sw_meta_q  <= 10'h0;
      sw_sync_q  <= 10'h0;
      key_meta_q <= 4'h0;
      key_sync_q <= 4'h0;
      key_prev_q <= 4'h0;
      press_q    <= 4'h0;
      timer_q    <= '0;
    end else begin
      sel_q      <= sel;
      periph_q   <= periph_d;
      ledr_q     <= ledr_d;
      sw_meta_q  <= SW;
      sw_sync_q  <= sw_meta_q;
      key_meta_q <= ~KEY;
      key_sync_q <= key_meta_q;
      key_prev_q <= key_sync_q;
      press_q    <= press_d;
      timer_q    <= timer_d;
    end
  end

  // sel_q resets to an unmapped region so din reads zero straight out of reset.
  assign din  = sel_q[3] ? periph_q : ram_rd_q;
  assign LEDR = ledr_q;

endmodule

// File: tb/tb_bus_io_ctrl.sv
// Directed bench for bus_io_ctrl: RAM read/write ordering, LEDR, SW and KEY
// synchronizers, sticky key flags with write-one-to-clear, timer load/wrap and
// asynchronous reset.
module tb_bus_io_ctrl;

  logic        clk;
  logic        reset;
  logic [31:0] realaddr;
  logic [31:0] dout;
  logic        W;
  logic [31:0] din;
  logic [9:0]  SW;
  logic [3:0]  KEY;
  logic [9:0]  LEDR;

  int n_checks;
  int n_errors;

  bus_io_ctrl #(.RAM_AW(12), .TIMER_W(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .realaddr (realaddr),
    .dout     (dout),
    .W        (W),
    .din      (din),
    .SW       (SW),
    .KEY      (KEY),
    .LEDR     (LEDR)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and land 1ns after it, away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic w, input logic [31:0] d);
    realaddr = a;
    W        = w;
    dout     = d;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset    = 1'b1;
    SW       = 10'h0;
    KEY      = 4'hF;
    drive(32'h0000_B000, 1'b0, 32'h0);

    // Reset held for three cycles.
    repeat (3) tick();
    chk("reset_din", din, 32'h0);
    chk("reset_ledr", {22'b0, LEDR}, 32'h0);
    reset = 1'b0;

    // First timer read after release sees 0, then it counts.
    tick();
    chk("timer_first", din, 32'h0);
    tick();
    chk("timer_second", din, 32'h1);

    drive(32'h0000_A000, 1'b0, 32'h0);
    tick();
    chk("key_after_reset", din, 32'h0);

    // RAM write then read.
    drive(32'h0000_0005, 1'b1, 32'hDEAD_BEEF);
    tick();
    drive(32'h0000_0005, 1'b0, 32'h0);
    tick();
    chk("ram_read", din, 32'hDEAD_BEEF);

    // Write and read of the same word on one edge returns the old data.
    drive(32'h0000_0005, 1'b1, 32'h0000_0001);
    tick();
    chk("ram_rdw_old", din, 32'hDEAD_BEEF);
    drive(32'h0000_0005, 1'b0, 32'h0);
    tick();
    chk("ram_rdw_new", din, 32'h0000_0001);

    // Aliasing: region 0x1 and address bits above 15 map to the same word.
    drive(32'h0001_1005, 1'b0, 32'h0);
    tick();
    chk("ram_alias", din, 32'h0000_0001);

    // A different word remains independent.
    drive(32'h0000_0006, 1'b1, 32'h1234_5678);
    tick();
    drive(32'h0000_0005, 1'b0, 32'h0);
    tick();
    chk("ram_other_word", din, 32'h0000_0001);

    // LEDR write, read back, and unmapped region.
    drive(32'h0000_8000, 1'b1, 32'h0000_03FF);
    tick();
    chk("ledr_out", {22'b0, LEDR}, 32'h0000_03FF);
    drive(32'h0000_8000, 1'b0, 32'h0);
    tick();
    chk("ledr_read", din, 32'h0000_03FF);
    drive(32'h0000_C000, 1'b1, 32'h0000_0123);
    tick();
    drive(32'h0000_C000, 1'b0, 32'h0);
    tick();
    chk("unmapped_read", din, 32'h0);
    chk("unmapped_no_ledr", {22'b0, LEDR}, 32'h0000_03FF);
    drive(32'h0000_8000, 1'b1, 32'hFFFF_F155);
    tick();
    drive(32'h0000_8000, 1'b0, 32'h0);
    tick();
    chk("ledr_mask", din, 32'h0000_0155);

    // SW through the synchronizer: visible on the third read edge.
    SW = 10'h2A5;
    drive(32'h0000_9000, 1'b0, 32'h0);
    repeat (3) tick();
    chk("sw_read", din, 32'h0000_02A5);
    drive(32'h0000_9000, 1'b1, 32'h0000_0000);
    tick();
    drive(32'h0000_9000, 1'b0, 32'h0);
    tick();
    chk("sw_write_ignored", din, 32'h0000_02A5);

    // KEY[2] pressed for five cycles, then released.
    drive(32'h0000_A000, 1'b0, 32'h0);
    KEY = 4'b1011;
    repeat (5) tick();
    chk("key_held", din, 32'h0000_0044);
    KEY = 4'hF;
    repeat (4) tick();
    chk("key_released", din, 32'h0000_0040);

    // Clearing a different flag leaves bit 2 set.
    drive(32'h0000_A000, 1'b1, 32'h0000_0010);
    tick();
    drive(32'h0000_A000, 1'b0, 32'h0);
    tick();
    chk("key_w1c_other", din, 32'h0000_0040);

    // Clearing bit 2.
    drive(32'h0000_A000, 1'b1, 32'h0000_0040);
    tick();
    drive(32'h0000_A000, 1'b0, 32'h0);
    tick();
    chk("key_w1c", din, 32'h0);

    // Timer load and wrap.
    drive(32'h0000_B000, 1'b1, 32'hFFFF_FFFE);
    tick();
    drive(32'h0000_B000, 1'b0, 32'h0);
    tick();
    chk("timer_load", din, 32'hFFFF_FFFE);
    tick();
    chk("timer_max", din, 32'hFFFF_FFFF);
    tick();
    chk("timer_wrap", din, 32'h0);
    tick();
    chk("timer_after_wrap", din, 32'h1);

    // Asynchronous reset mid-operation.
    drive(32'h0000_0005, 1'b0, 32'h0);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_din", din, 32'h0);
    chk("async_rst_ledr", {22'b0, LEDR}, 32'h0);
    #2;
    reset = 1'b0;
    tick();
    chk("ram_survives_reset", din, 32'h0000_0001);
    drive(32'h0000_8000, 1'b0, 32'h0);
    tick();
    chk("ledr_read_after_reset", din, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
